// File: rtl/half_pel_interp.sv
// Half-pel interpolator: fetches a 7x7 window, runs six-tap H/V/diagonal filters, emits a 3x3 sub-pel grid.
// Quarter-pel averaging of the grid is built only when HALF_PEL_QPEL_AVG_EN is defined.
module half_pel_interp #(
  parameter int PIX_W  = 8,
  parameter int STRIDE = 16,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  center_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic               busy,
  output logic               done,
  output logic [9*PIX_W-1:0] half_out,
  output logic [4*PIX_W-1:0] qpel_out
);

  localparam int IM_W  = PIX_W + 7;
  localparam int ACC_W = PIX_W + 14;

  localparam logic [5:0] LAST_ISSUE = 6'd48;
  localparam logic [5:0] CAP_FIRST  = 6'd2;
  localparam logic [5:0] FETCH_LAST = 6'd50;
  localparam logic [5:0] HFILT_LAST = 6'd13;
  localparam logic [5:0] VFILT_LAST = 6'd5;

  localparam logic [ADDR_W-1:0] ADDR_OFS = ADDR_W'(3 * STRIDE + 3);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE - 6);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  localparam logic signed [ACC_W-1:0] K5      = ACC_W'(5);
  localparam logic signed [ACC_W-1:0] K20     = ACC_W'(20);
  localparam logic signed [ACC_W-1:0] RND5    = ACC_W'(16);
  localparam logic signed [ACC_W-1:0] RND10   = ACC_W'(512);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [2:0] {IDLE, FETCH, HFILT, VFILT, DONE} state_t;

  state_t state, next_state;

  logic [5:0]        cnt;
  logic [2:0]        iss_col, cap_row, cap_col;
  logic [ADDR_W-1:0] next_addr;

  logic [PIX_W-1:0]        win   [7][7];
  logic signed [IM_W-1:0]  h_m   [7];
  logic signed [IM_W-1:0]  h_p   [7];
  logic [PIX_W-1:0]        stage [9];

  logic [2:0]              row_sel;
  logic [3:0]              cur_slot;
  logic                    wide_rnd;
  logic signed [ACC_W-1:0] taps [6];
  logic signed [ACC_W-1:0] fir_sum, rnd_sum;
  logic [PIX_W-1:0]        fir_pix, half_m_pix, half_p_pix;
  logic [PIX_W-1:0]        grid [9];
  logic [9*PIX_W-1:0]      half_next;
  logic                    load_out;

  function automatic logic [PIX_W-1:0] clip_pix(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (v > PIX_MAX)
      return '1;
    else
      return v[PIX_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (cnt == FETCH_LAST) next_state = HFILT;
      HFILT:   if (cnt == HFILT_LAST) next_state = VFILT;
      VFILT:   if (cnt == VFILT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy     = (state == FETCH) || (state == HFILT) || (state == VFILT);
  assign done     = (state == DONE);
  assign load_out = (state == VFILT) && (cnt == VFILT_LAST);

  // One shared six-tap datapath: HFILT walks 7 rows left then right, VFILT walks the six vertical jobs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    row_sel  = '0;
    cur_slot = '0;
    wide_rnd = 1'b0;
    for (int i = 0; i < 6; i++) taps[i] = '0;
    if (state == HFILT) begin
      if (cnt < 6'd7) begin
        row_sel = cnt[2:0];
        for (int i = 0; i < 6; i++) taps[i] = ACC_W'(win[row_sel][i]);
      end else begin
        row_sel = 3'(cnt - 6'd7);
        for (int i = 0; i < 6; i++) taps[i] = ACC_W'(win[row_sel][i+1]);
      end
    end else if (state == VFILT) begin
      case (cnt[2:0])
        3'd0: begin
          cur_slot = 4'd1;
          for (int i = 0; i < 6; i++) taps[i] = ACC_W'(win[i][3]);
        end
        3'd1: begin
          cur_slot = 4'd7;
          for (int i = 0; i < 6; i++) taps[i] = ACC_W'(win[i+1][3]);
        end
        3'd2: begin
          cur_slot = 4'd0;
          wide_rnd = 1'b1;
          for (int i = 0; i < 6; i++) taps[i] = ACC_W'(h_m[i]);
        end
        3'd3: begin
          cur_slot = 4'd2;
          wide_rnd = 1'b1;
          for (int i = 0; i < 6; i++) taps[i] = ACC_W'(h_p[i]);
        end
        3'd4: begin
          cur_slot = 4'd6;
          wide_rnd = 1'b1;
          for (int i = 0; i < 6; i++) taps[i] = ACC_W'(h_m[i+1]);
        end
        default: begin
          cur_slot = 4'd8;
          wide_rnd = 1'b1;
          for (int i = 0; i < 6; i++) taps[i] = ACC_W'(h_p[i+1]);
        end
      endcase
    end
  end

  assign fir_sum = taps[0] - K5 * taps[1] + K20 * taps[2]
                 + K20 * taps[3] - K5 * taps[4] + taps[5];
  assign rnd_sum = wide_rnd ? (fir_sum + RND10) >>> 10 : (fir_sum + RND5) >>> 5;
  assign fir_pix = clip_pix(rnd_sum);

  assign half_m_pix = clip_pix((ACC_W'(h_m[3]) + RND5) >>> 5);
  assign half_p_pix = clip_pix((ACC_W'(h_p[3]) + RND5) >>> 5);

  // Slot 8 is produced in the final VFILT cycle, so it bypasses the stage registers.
  always_comb begin
    for (int k = 0; k < 9; k++) grid[k] = stage[k];
    grid[3] = half_m_pix;
    grid[4] = win[3][3];
    grid[5] = half_p_pix;
    grid[8] = fir_pix;
  end

  always_comb begin
    half_next = '0;
    for (int k = 0; k < 9; k++) half_next[k*PIX_W +: PIX_W] = grid[k];
  end

  // NOTE: window and filter storage carry no reset; control never reads them before they are written.
  always_ff @(posedge clk) begin
    if (state == FETCH && cnt >= CAP_FIRST && cnt <= FETCH_LAST)
      win[cap_row][cap_col] <= mem_rdata;
    if (state == HFILT) begin
      if (cnt < 6'd7) h_m[row_sel] <= IM_W'(fir_sum);
      else            h_p[row_sel] <= IM_W'(fir_sum);
    end
    if (state == VFILT)
      stage[cur_slot] <= fir_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mem_addr  <= '0;
      next_addr <= '0;
      iss_col   <= '0;
      cap_row   <= '0;
      cap_col   <= '0;
      half_out  <= '0;
    end else begin
      if (state == IDLE || next_state != state) cnt <= '0;
      else                                      cnt <= cnt + 6'd1;

      case (state)
        IDLE: if (start) begin
          next_addr <= center_addr - ADDR_OFS;
          iss_col   <= '0;
          cap_row   <= '0;
          cap_col   <= '0;
        end
        FETCH: begin
          if (cnt <= LAST_ISSUE) begin
            mem_addr <= next_addr;
            if (iss_col == 3'd6) begin
              next_addr <= next_addr + ROW_STEP;
              iss_col   <= '0;
            end else begin
              next_addr <= next_addr + ADDR_ONE;
              iss_col   <= iss_col + 3'd1;
            end
          end
          if (cnt >= CAP_FIRST) begin
            if (cap_col == 3'd6) begin
              cap_col <= '0;
              cap_row <= cap_row + 3'd1;
            end else begin
              cap_col <= cap_col + 3'd1;
            end
          end
        end
        default: ;
      endcase

      if (load_out) half_out <= half_next;
    end
  end

`ifdef HALF_PEL_QPEL_AVG_EN
  localparam int QM [4] = '{1, 3, 5, 7};

  logic [4*PIX_W-1:0] qpel_next;
  logic [PIX_W:0]     qsum [4];

  always_comb begin
    qpel_next = '0;
    for (int i = 0; i < 4; i++) begin
      qsum[i] = {1'b0, grid[4]} + {1'b0, grid[QM[i]]} + (PIX_W+1)'(1);
      qpel_next[i*PIX_W +: PIX_W] = qsum[i][PIX_W:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           qpel_out <= '0;
    else if (load_out) qpel_out <= qpel_next;
  end
`else
  assign qpel_out = '0;
`endif

endmodule

// File: tb/tb_half_pel_interp.sv
// Randomised bench for half_pel_interp against a direct 2-D six-tap reference model.
module tb_half_pel_interp;

  localparam int PIX_W  = 8;
  localparam int STRIDE = 16;
  localparam int ADDR_W = 8;
  localparam int KER [6] = '{1, -5, 20, 20, -5, 1};
  localparam int QM  [4] = '{1, 3, 5, 7};

  logic        clk, rst, start;
  logic [7:0]  center_addr, mem_addr, mem_rdata;
  logic        busy, done;
  logic [71:0] half_out;
  logic [31:0] qpel_out;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_pass   = 0;

  half_pel_interp #(.PIX_W(PIX_W), .STRIDE(STRIDE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .center_addr(center_addr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .half_out(half_out), .qpel_out(qpel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int pix(int c, int dy, int dx);
    return int'(mem[(c + dy * STRIDE + dx) & 255]);
  endfunction

  function automatic int exp_addr(int c, int i);
    return (c + (i / 7 - 3) * STRIDE + (i % 7 - 3)) & 255;
  endfunction

  function automatic int clip8(int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Unrounded horizontal half sample at row dy; side 0 = -0.5, side 1 = +0.5.
  function automatic int h_half_sum(int c, int dy, int side);
    int s = 0;
    for (int j = 0; j < 6; j++) s += KER[j] * pix(c, dy, j - 3 + side);
    return s;
  endfunction

  function automatic int exp_slot(int c, int k);
    int ry = k / 3;
    int rx = k % 3;
    int s  = 0;
    if (ry == 1 && rx == 1) return pix(c, 0, 0);
    if (ry == 1) return clip8((h_half_sum(c, 0, rx / 2) + 16) >>> 5);
    if (rx == 1) begin
      for (int j = 0; j < 6; j++) s += KER[j] * pix(c, j - 3 + ry / 2, 0);
      return clip8((s + 16) >>> 5);
    end
    for (int j = 0; j < 6; j++) s += KER[j] * h_half_sum(c, j - 3 + ry / 2, rx / 2);
    return clip8((s + 512) >>> 10);
  endfunction

  task automatic fill_const(input int v);
    for (int i = 0; i < 256; i++) mem[i] = 8'(v);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Call between clock edges with the DUT idle; returns at the falling edge one cycle after done.
  task automatic run_op(input int c, input bit hold);
    int          ex [9];
    logic [71:0] exp_half;
    logic [31:0] exp_qpel;
    bit          busy_bad, early_done;
    for (int k = 0; k < 9; k++) begin
      ex[k] = exp_slot(c, k);
      exp_half[k*8 +: 8] = 8'(ex[k]);
    end
    for (int i = 0; i < 4; i++) begin
`ifdef HALF_PEL_QPEL_AVG_EN
      exp_qpel[i*8 +: 8] = 8'((ex[4] + ex[QM[i]] + 1) / 2);
`else
      exp_qpel[i*8 +: 8] = 8'(0);
`endif
    end
    busy_bad   = 1'b0;
    early_done = 1'b0;
    rst         = 1'b0;
    start       = 1'b1;
    center_addr = 8'(c);
    @(posedge clk);
    for (int n = 0; n <= 72; n++) begin
      @(negedge clk);
      if (n == 0 && !hold) start = 1'b0;
      center_addr = 8'($urandom_range(0, 255));
      if (n >= 1 && n <= 49)
        check($sformatf("addr%0d", n - 1), 64'(mem_addr), 64'(exp_addr(c, n - 1)));
      if (n <= 70) begin
        if (!busy) busy_bad = 1'b1;
        if (done)  early_done = 1'b1;
      end
      if (n == 71) begin
        check("busy_during_op", 64'(busy_bad), 64'(0));
        check("done_early", 64'(early_done), 64'(0));
        check("done_at_71", 64'(done), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        for (int k = 0; k < 9; k++)
          check($sformatf("half%0d", k), 64'(half_out[k*8 +: 8]), 64'(ex[k]));
        check("qpel", 64'(qpel_out), 64'(exp_qpel));
      end
      if (n == 72) begin
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'(0));
        check("half_held", 64'(half_out === exp_half), 64'(1));
        check("qpel_held", 64'(qpel_out), 64'(exp_qpel));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int done_at [$];
    rst         = 1'b1;
    start       = 1'b0;
    center_addr = 8'h00;
    fill_const(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_half", 64'(half_out == 72'd0), 64'(1));
    check("rst_qpel", 64'(qpel_out), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));

    // Flat field: every sub-pel sample equals the field value.
    fill_const(100);
    run_op(8'h44, 1'b0);
    check("flat_h0", 64'(half_out[7:0]), 64'(100));
    check("flat_h8", 64'(half_out[71:64]), 64'(100));
`ifdef HALF_PEL_QPEL_AVG_EN
    check("flat_q0", 64'(qpel_out[7:0]), 64'(100));
`else
    check("flat_q0", 64'(qpel_out[7:0]), 64'(0));
`endif

    // Single bright centre pixel.
    fill_const(0);
    mem[8'h80] = 8'd255;
    run_op(8'h80, 1'b0);
    check("impulse_h3", 64'(half_out[31:24]), 64'(159));
    check("impulse_h5", 64'(half_out[47:40]), 64'(159));
    check("impulse_h4", 64'(half_out[39:32]), 64'(255));
    check("impulse_h1", 64'(half_out[15:8]), 64'(159));

    // Bright pixel left of centre: negative lobe clips to zero on the right half.
    fill_const(0);
    mem[8'h7F] = 8'd255;
    run_op(8'h80, 1'b0);
    check("left_h5", 64'(half_out[47:40]), 64'(0));
    check("left_h3", 64'(half_out[31:24]), 64'(159));

    // Address wrap below zero.
    fill_rand();
    run_op(8'h01, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_rand();
      run_op($urandom_range(0, 255), r == 1);
    end

    // Abort mid-FETCH, then restart in the very next cycle.
    fill_rand();
    rst         = 1'b0;
    start       = 1'b1;
    center_addr = 8'h30;
    @(posedge clk);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 29) rst = 1'b1;
    end
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_half", 64'(half_out == 72'd0), 64'(1));
    check("abort_qpel", 64'(qpel_out), 64'(0));
    check("abort_addr", 64'(mem_addr), 64'(0));
    run_op(8'h5A, 1'b0);

    // Continuous start requests: only accepted from IDLE.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_at.push_back(k);
    end
    start = 1'b0;
    check("stream_count", 64'(done_at.size()), 64'(2));
    check("stream_first", 64'(done_at.size() > 0 ? done_at[0] : -1), 64'(71));
    check("stream_second", 64'(done_at.size() > 1 ? done_at[1] : -1), 64'(144));
    for (int w = 0; w < 100 && (busy || done); w++) @(negedge clk);
    check("stream_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
